// File: rtl/mem_access_pkg.sv
// Shared definitions for the MEM stage: FSM state encodings, timeout defaults
// and the MEM/WB pipeline register layout.
package mem_access_pkg;

  localparam logic [1:0] MEM_IDLE      = 2'd0;
  localparam logic [1:0] MEM_WAIT_GNT  = 2'd1;
  localparam logic [1:0] MEM_WAIT_RESP = 2'd2;

  localparam int DEFAULT_TIMEOUT = 255;
  localparam int CNT_W           = 8;

  typedef struct packed {
    logic [31:0] mem_data;
    logic [31:0] alu_result;
    logic [4:0]  reg_dst;
    logic        mem_to_reg;
    logic        reg_wr_en;
  } memwb_t;

endpackage

// File: rtl/dmem_if_fsm.sv
// Data-memory request/grant/response sequencer: single outstanding access,
// timeout counter, and the stall / bus-error / load-completion strobes.
module dmem_if_fsm
  import mem_access_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic i_load,
  input  logic i_store,
  input  logic i_misaligned,
  input  logic i_gnt,
  input  logic i_rvalid,
  output logic o_req,
  output logic o_stall,
  output logic o_bus_err,
  output logic o_load_done
);

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             req, stall, bus_err, load_done;
  logic             expired;

  assign expired = (cnt_q == TIMEOUT_CNT);

  // NOTE: every signal gets a default at the top of the block so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    req       = 1'b0;
    stall     = 1'b0;
    bus_err   = 1'b0;
    load_done = 1'b0;
    case (state_q)
      MEM_IDLE: begin
        cnt_d = '0;
        if (i_load || i_store) begin
          if (i_misaligned) begin
            bus_err = 1'b1;
          end else begin
            req = 1'b1;
            if (!(i_store && i_gnt)) begin
              stall   = 1'b1;
              state_d = i_gnt ? MEM_WAIT_RESP : MEM_WAIT_GNT;
            end
          end
        end
      end
      MEM_WAIT_GNT: begin
        req = 1'b1;
        if (i_gnt) begin
          if (i_store) begin
            state_d = MEM_IDLE;
          end else begin
            stall   = 1'b1;
            state_d = MEM_WAIT_RESP;
            cnt_d   = '0;
          end
        end else if (expired) begin
          bus_err = 1'b1;
          state_d = MEM_IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      MEM_WAIT_RESP: begin
        if (i_rvalid) begin
          load_done = 1'b1;
          state_d   = MEM_IDLE;
        end else if (expired) begin
          bus_err = 1'b1;
          state_d = MEM_IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      default: begin
        state_d = MEM_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Reset wins over any in-flight access: the bus is released in the reset cycle itself.
  assign o_req       = req & ~reset;
  assign o_stall     = stall & ~reset;
  assign o_bus_err   = bus_err & ~reset;
  assign o_load_done = load_done & ~reset;

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= MEM_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_access.sv
// MEM stage of the Light RV32I pipeline: data-memory access, branch/jump
// redirection and the MEM/WB pipeline register.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] i_pipe_TargetAddr,
  input  logic [31:0] i_pipe_AluResult,
  input  logic        i_pipe_Zero,
  input  logic [31:0] i_pipe_Reg2Data,
  input  logic [4:0]  i_pipe_RegDst,
  input  logic        i_pipe_MemToReg,
  input  logic        i_pipe_RegWrEn,
  input  logic        i_pipe_MemWrEn,
  input  logic        i_pipe_Branch,
  input  logic        i_pipe_Jump,
  output logic        o_dmem_req,
  output logic        o_dmem_we,
  output logic [31:0] o_dmem_addr,
  output logic [31:0] o_dmem_wdata,
  input  logic        i_dmem_gnt,
  input  logic        i_dmem_rvalid,
  input  logic [31:0] i_dmem_rdata,
  output logic        o_stall,
  output logic        o_PCSrc,
  output logic [31:0] o_PCTarget,
  output logic        o_bus_err,
  output logic [31:0] o_pipe_MemData,
  output logic [31:0] o_pipe_AluResult,
  output logic [4:0]  o_pipe_RegDst,
  output logic        o_pipe_MemToReg,
  output logic        o_pipe_RegWrEn
);

  logic   is_load, is_store, misaligned, load_done;
  memwb_t wb_d, wb_q;

  // MemToReg together with MemWrEn is treated as a store.
  assign is_store   = i_pipe_MemWrEn;
  assign is_load    = i_pipe_MemToReg & ~i_pipe_MemWrEn;
  assign misaligned = (is_load | is_store) & (i_pipe_AluResult[1:0] != 2'b00);

  dmem_if_fsm #(.TIMEOUT(TIMEOUT)) u_dmem_if_fsm (
    .clk          (clk),
    .reset        (reset),
    .i_load       (is_load),
    .i_store      (is_store),
    .i_misaligned (misaligned),
    .i_gnt        (i_dmem_gnt),
    .i_rvalid     (i_dmem_rvalid),
    .o_req        (o_dmem_req),
    .o_stall      (o_stall),
    .o_bus_err    (o_bus_err),
    .o_load_done  (load_done)
  );

  // Upstream holds EX/MEM stable while stalled, so the bus fields stay put in WAIT_GNT.
  assign o_dmem_we    = is_store;
  assign o_dmem_addr  = {i_pipe_AluResult[31:2], 2'b00};
  assign o_dmem_wdata = i_pipe_Reg2Data;

  assign o_PCSrc    = (i_pipe_Branch & i_pipe_Zero) | i_pipe_Jump;
  assign o_PCTarget = i_pipe_TargetAddr;

  // Stalled or aborted cycles leave an all-zero bubble so WB never writes twice.
  always_comb begin
    wb_d = '0;
    if (!(o_stall || o_bus_err)) begin
      wb_d.alu_result = i_pipe_AluResult;
      wb_d.reg_dst    = i_pipe_RegDst;
      if (load_done) begin
        wb_d.mem_data   = i_dmem_rdata;
        wb_d.mem_to_reg = i_pipe_MemToReg;
        wb_d.reg_wr_en  = i_pipe_RegWrEn;
      end else if (!is_store) begin
        wb_d.mem_to_reg = i_pipe_MemToReg;
        wb_d.reg_wr_en  = i_pipe_RegWrEn;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) wb_q <= '0;
    else       wb_q <= wb_d;
  end

  assign o_pipe_MemData   = wb_q.mem_data;
  assign o_pipe_AluResult = wb_q.alu_result;
  assign o_pipe_RegDst    = wb_q.reg_dst;
  assign o_pipe_MemToReg  = wb_q.mem_to_reg;
  assign o_pipe_RegWrEn   = wb_q.reg_wr_en;

endmodule
